// File: rtl/pe_row_feeder.sv
// Input staging for a 4-PE systolic row: accepts packed beats, skews lane k by
// (k-1)*SKEW cycles, drives the row enable and reports burst completion.
module pe_row_feeder #(
    parameter int IMG_W  = 24,
    parameter int WGT_W  = 36,
    parameter int PSUM_W = 16,
    parameter int SKEW   = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [4*IMG_W-1:0]   in_img,
    input  logic [4*WGT_W-1:0]   in_wgt,
    input  logic [PSUM_W-1:0]    in_psum,
    input  logic [4:0]           in_exp_bias,
    output logic [4:0]           exp_bias,
    output logic [IMG_W-1:0]     img1,
    output logic [IMG_W-1:0]     img2,
    output logic [IMG_W-1:0]     img3,
    output logic [IMG_W-1:0]     img4,
    output logic [WGT_W-1:0]     wgt1,
    output logic [WGT_W-1:0]     wgt2,
    output logic [WGT_W-1:0]     wgt3,
    output logic [WGT_W-1:0]     wgt4,
    output logic [PSUM_W-1:0]    psum,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam int LAST_D = 1 + 3 * SKEW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic [4:0]          exp_bias_q, exp_bias_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LAST_D-1:0]   last_q, last_d;
    logic [PSUM_W-1:0]   psum_q, psum_d;
    logic                accept_s;
    logic [3:0][IMG_W-1:0] img_out_s;
    logic [3:0][WGT_W-1:0] wgt_out_s;
    logic [3:0]          vld_out_s;

    assign accept_s = in_valid & in_ready;
    assign in_ready = in_ready_q & rst;

    // Burst FSM, bias capture and saturating beat counter
    always_comb begin
        state_d    = state_q;
        exp_bias_d = exp_bias_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    exp_bias_d = in_exp_bias;
                    beat_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d    = in_last ? DRAIN : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    if (beat_cnt_q != {CNT_W{1'b1}}) begin
                        beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                    state_d = in_last ? DRAIN : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                state_d = last_q[LAST_D-1] ? IDLE : DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d != DRAIN);
        busy_d     = (state_d != IDLE);
    end

    // Lane-1 psum and the last-beat marker that follows lane 4
    always_comb begin
        psum_d = accept_s ? in_psum : {PSUM_W{1'b0}};
        last_d = {last_q[LAST_D-2:0], accept_s & in_last};
    end

    // Control and lane-1 psum registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            exp_bias_q <= 5'd0;
            beat_cnt_q <= {CNT_W{1'b0}};
            last_q     <= {LAST_D{1'b0}};
            psum_q     <= {PSUM_W{1'b0}};
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            exp_bias_q <= exp_bias_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            psum_q     <= psum_d;
        end
    end

    // Invalid slots are stored as zeros so outputs need no gating downstream
    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam int DEPTH = 1 + g * SKEW;

        logic [IMG_W-1:0] img_q [DEPTH];
        logic [IMG_W-1:0] img_d [DEPTH];
        logic [WGT_W-1:0] wgt_q [DEPTH];
        logic [WGT_W-1:0] wgt_d [DEPTH];
        logic [DEPTH-1:0] vld_q, vld_d;

        // Shift the lane one stage per cycle, injecting the new slot at stage 0
        always_comb begin
            img_d[0] = accept_s ? in_img[g*IMG_W +: IMG_W] : {IMG_W{1'b0}};
            wgt_d[0] = accept_s ? in_wgt[g*WGT_W +: WGT_W] : {WGT_W{1'b0}};
            vld_d[0] = accept_s;
            for (int i = 1; i < DEPTH; i++) begin
                img_d[i] = img_q[i-1];
                wgt_d[i] = wgt_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
        end

        // Lane storage registers
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    img_q[i] <= {IMG_W{1'b0}};
                    wgt_q[i] <= {WGT_W{1'b0}};
                end
                vld_q <= {DEPTH{1'b0}};
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    img_q[i] <= img_d[i];
                    wgt_q[i] <= wgt_d[i];
                end
                vld_q <= vld_d;
            end
        end

        assign img_out_s[g] = img_q[DEPTH-1];
        assign wgt_out_s[g] = wgt_q[DEPTH-1];
        assign vld_out_s[g] = vld_q[DEPTH-1];
    end

    assign img1     = img_out_s[0];
    assign img2     = img_out_s[1];
    assign img3     = img_out_s[2];
    assign img4     = img_out_s[3];
    assign wgt1     = wgt_out_s[0];
    assign wgt2     = wgt_out_s[1];
    assign wgt3     = wgt_out_s[2];
    assign wgt4     = wgt_out_s[3];
    assign psum     = psum_q;
    assign en       = |vld_out_s;
    assign busy     = busy_q;
    assign done     = last_q[LAST_D-1];
    assign exp_bias = exp_bias_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Bench for pe_row_feeder: two instances (SKEW=1, SKEW=2) driven side by side and
// compared every cycle against a slot-history reference model.
module tb_pe_row_feeder;

    localparam int IMG_W = 24;
    localparam int WGT_W = 36;
    localparam int PSUM_W = 16;
    localparam int CNT_W = 8;
    localparam int HN = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_i [2];
    logic                vld_i [2];
    logic                last_i [2];
    logic                rdy_o [2];
    logic [4*IMG_W-1:0]  img_i [2];
    logic [4*WGT_W-1:0]  wgt_i [2];
    logic [PSUM_W-1:0]   psum_i [2];
    logic [4:0]          bias_i [2];
    logic [4:0]          bias_o [2];
    logic [IMG_W-1:0]    img_o [2][4];
    logic [WGT_W-1:0]    wgt_o [2][4];
    logic [PSUM_W-1:0]   psum_o [2];
    logic                en_o [2];
    logic                busy_o [2];
    logic                done_o [2];
    logic [CNT_W-1:0]    cnt_o [2];

    pe_row_feeder #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .SKEW(1), .CNT_W(CNT_W)) u_s1 (
        .clk(clk), .rst(rst_i[0]), .in_valid(vld_i[0]), .in_ready(rdy_o[0]), .in_last(last_i[0]),
        .in_img(img_i[0]), .in_wgt(wgt_i[0]), .in_psum(psum_i[0]), .in_exp_bias(bias_i[0]),
        .exp_bias(bias_o[0]),
        .img1(img_o[0][0]), .img2(img_o[0][1]), .img3(img_o[0][2]), .img4(img_o[0][3]),
        .wgt1(wgt_o[0][0]), .wgt2(wgt_o[0][1]), .wgt3(wgt_o[0][2]), .wgt4(wgt_o[0][3]),
        .psum(psum_o[0]), .en(en_o[0]), .busy(busy_o[0]), .done(done_o[0]), .beat_cnt(cnt_o[0]));

    pe_row_feeder #(.IMG_W(IMG_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W), .SKEW(2), .CNT_W(CNT_W)) u_s2 (
        .clk(clk), .rst(rst_i[1]), .in_valid(vld_i[1]), .in_ready(rdy_o[1]), .in_last(last_i[1]),
        .in_img(img_i[1]), .in_wgt(wgt_i[1]), .in_psum(psum_i[1]), .in_exp_bias(bias_i[1]),
        .exp_bias(bias_o[1]),
        .img1(img_o[1][0]), .img2(img_o[1][1]), .img3(img_o[1][2]), .img4(img_o[1][3]),
        .wgt1(wgt_o[1][0]), .wgt2(wgt_o[1][1]), .wgt3(wgt_o[1][2]), .wgt4(wgt_o[1][3]),
        .psum(psum_o[1]), .en(en_o[1]), .busy(busy_o[1]), .done(done_o[1]), .beat_cnt(cnt_o[1]));

    // Reference model: what was accepted at each edge, plus burst bookkeeping.
    bit                  hv [2][HN];
    bit                  hlast [2][HN];
    logic [4*IMG_W-1:0]  himg [2][HN];
    logic [4*WGT_W-1:0]  hwgt [2][HN];
    logic [PSUM_W-1:0]   hpsum [2][HN];
    int                  sk [2];
    int                  rst_edge [2];
    int                  drain_end [2];
    bit                  active [2];
    bit                  rdy_q [2];
    logic [4:0]          m_bias [2];
    int                  m_cnt [2];

    bit                  n_rst [2];
    bit                  n_vld [2];
    bit                  n_last [2];
    logic [4*IMG_W-1:0]  n_img [2];
    logic [4*WGT_W-1:0]  n_wgt [2];
    logic [PSUM_W-1:0]   n_psum [2];
    logic [4:0]          n_bias [2];

    int cyc = 0;
    int cur = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", tag, cur, cyc, obs, exp);
        end
    endtask

    task automatic apply(input int i);
        int e;
        bit acc;
        e = cyc + 1;
        acc = n_rst[i] && rdy_q[i] && n_vld[i];
        rst_i[i]  = n_rst[i];
        vld_i[i]  = n_vld[i];
        last_i[i] = n_last[i];
        img_i[i]  = n_img[i];
        wgt_i[i]  = n_wgt[i];
        psum_i[i] = n_psum[i];
        bias_i[i] = n_bias[i];
        if (!n_rst[i]) begin
            rst_edge[i]  = e;
            active[i]    = 1'b0;
            drain_end[i] = -1;
            m_cnt[i]     = 0;
            m_bias[i]    = 5'd0;
        end else if (acc) begin
            if (!active[i]) begin
                m_bias[i] = n_bias[i];
                m_cnt[i]  = 1;
            end else if (m_cnt[i] < (1 << CNT_W) - 1) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            if (n_last[i]) begin
                active[i]    = 1'b0;
                drain_end[i] = e + 3 * sk[i];
            end else begin
                active[i] = 1'b1;
            end
        end
        hv[i][e]    = acc;
        hlast[i][e] = acc && n_last[i];
        himg[i][e]  = n_img[i];
        hwgt[i][e]  = n_wgt[i];
        hpsum[i][e] = n_psum[i];
        rdy_q[i] = n_rst[i] && !(e <= drain_end[i]);
    endtask

    task automatic check_inst(input int i);
        int idx;
        bit v;
        bit any;
        cur = i;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = cyc - k * sk[i];
            v = 1'b0;
            if (idx > rst_edge[i] && idx >= 0) v = hv[i][idx];
            any = any | v;
            chk($sformatf("img%0d", k + 1), 64'(img_o[i][k]),
                v ? 64'(himg[i][idx][k*IMG_W +: IMG_W]) : 64'd0);
            chk($sformatf("wgt%0d", k + 1), 64'(wgt_o[i][k]),
                v ? 64'(hwgt[i][idx][k*WGT_W +: WGT_W]) : 64'd0);
            if (k == 0) chk("psum", 64'(psum_o[i]), v ? 64'(hpsum[i][idx]) : 64'd0);
            if (k == 3) chk("done", 64'(done_o[i]), 64'(v && hlast[i][idx]));
        end
        chk("en", 64'(en_o[i]), 64'(any));
        chk("busy", 64'(busy_o[i]), 64'(active[i] || (cyc <= drain_end[i])));
        chk("in_ready", 64'(rdy_o[i]), 64'(rdy_q[i] && rst_i[i]));
        chk("beat_cnt", 64'(cnt_o[i]), 64'(m_cnt[i]));
        chk("exp_bias", 64'(bias_o[i]), 64'(m_bias[i]));
    endtask

    task automatic step();
        apply(0);
        apply(1);
        cyc++;
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic beat(input bit last, input logic [4:0] b);
        for (int i = 0; i < 2; i++) begin
            n_rst[i]  = 1'b1;
            n_vld[i]  = 1'b1;
            n_last[i] = last;
            n_img[i]  = {$urandom(), $urandom(), $urandom()};
            n_wgt[i]  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
            n_psum[i] = 16'($urandom());
            n_bias[i] = b;
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                n_rst[i]  = 1'b1;
                n_vld[i]  = 1'b0;
                n_last[i] = 1'b0;
                n_bias[i] = 5'($urandom());
            end
            step();
        end
    endtask

    task automatic fixed_beat();
        for (int i = 0; i < 2; i++) begin
            n_rst[i]  = 1'b1;
            n_vld[i]  = 1'b1;
            n_last[i] = 1'b1;
            n_img[i]  = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
            n_wgt[i]  = {36'h4, 36'h3, 36'h2, 36'h1};
            n_psum[i] = 16'h3C00;
            n_bias[i] = 5'd3;
        end
        step();
    endtask

    initial begin
        sk[0] = 1;
        sk[1] = 2;
        for (int i = 0; i < 2; i++) begin
            rst_edge[i]  = -1000;
            drain_end[i] = -1;
            active[i]    = 1'b0;
            rdy_q[i]     = 1'b0;
            m_bias[i]    = 5'd0;
            m_cnt[i]     = 0;
            n_img[i]     = '0;
            n_wgt[i]     = '0;
            n_psum[i]    = '0;
            n_bias[i]    = 5'd0;
            n_last[i]    = 1'b0;
        end

        // Reset held with in_valid high, then release
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 2; i++) begin
                n_rst[i] = 1'b0;
                n_vld[i] = 1'b1;
            end
            step();
        end
        idle(2);

        // Single-beat burst with known lane values
        fixed_beat();
        idle(10);

        // 8-beat back-to-back burst
        for (int j = 0; j < 8; j++) beat(j == 7, 5'd9);
        idle(12);

        // Beat, bubble, last beat
        beat(1'b0, 5'd4);
        idle(1);
        beat(1'b1, 5'd4);
        idle(10);

        // exp_bias must ignore mid-burst changes
        beat(1'b0, 5'd15);
        beat(1'b0, 5'd7);
        beat(1'b0, 5'd7);
        beat(1'b1, 5'd7);
        idle(10);
        beat(1'b1, 5'd7);
        idle(10);

        // Reset mid-burst, then a fresh single-beat burst
        for (int j = 0; j < 3; j++) beat(1'b0, 5'd2);
        for (int i = 0; i < 2; i++) begin
            n_rst[i] = 1'b0;
            n_vld[i] = 1'b1;
        end
        step();
        idle(1);
        fixed_beat();
        idle(10);

        // Long burst to drive beat_cnt into saturation
        for (int j = 0; j < 270; j++) beat(j == 269, 5'd1);
        idle(10);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                n_rst[i]  = ($urandom_range(0, 99) != 0);
                n_vld[i]  = ($urandom_range(0, 9) < 7);
                n_last[i] = ($urandom_range(0, 4) == 0);
                n_img[i]  = {$urandom(), $urandom(), $urandom()};
                n_wgt[i]  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
                n_psum[i] = 16'($urandom());
                n_bias[i] = 5'($urandom());
            end
            step();
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_row_feeder.md
Name: pe_row_feeder

Overview:
Input-staging block directly upstream of the 4-PE systolic row. It accepts one packed beat per cycle over a valid/ready handshake. Each beat carries 4 image words, 4 weight words and an initial psum. The block re-times each beat so that lane k reaches the row (k-1)*SKEW cycles after lane 1. This matches the psum ripple through the row's per-PE register stages. The block also generates the row enable, holds exp_bias stable per burst, and reports burst completion.

Parameters:
IMG_W, 24, width of one image word
WGT_W, 36, width of one weight word
PSUM_W, 16, psum width
SKEW, 1, cycles between adjacent lanes; legal range 1..4
CNT_W, 8, width of beat counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid & in_ready
in_last  in  1  marks final beat of a burst
in_img  in  4*IMG_W  lane1 = [IMG_W-1:0], lane4 = MSBs
in_wgt  in  4*WGT_W  same packing as in_img
in_psum  in  PSUM_W  initial psum for the beat
in_exp_bias  in  5  exponent bias for the burst
exp_bias  out  5  to row, stable for the whole burst
img1..img4  out  IMG_W each  skewed image lanes
wgt1..wgt4  out  WGT_W each  skewed weight lanes
psum  out  PSUM_W  psum injected alongside lane 1
en  out  1  row enable
busy  out  1  state != IDLE
done  out  1  one-cycle pulse
beat_cnt  out  CNT_W  beats accepted in current/last burst

Behaviour:
- Reset (rst==0 at edge):
  - State goes to IDLE; all skew registers and lane-valid bits are cleared.
  - All data outputs, en, done, busy and beat_cnt are 0; exp_bias is 0.
  - in_ready=0 while rst==0.
- Reset applied mid-burst discards all in-flight beats; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: in_ready=1. On accept, latch in_exp_bias into exp_bias and set beat_cnt=1. Go to DRAIN if in_last, otherwise go to RUN.
  - RUN: in_ready=1. Each accept increments beat_cnt, saturating at 2^CNT_W-1. Accept with in_last goes to DRAIN.
  - DRAIN: in_ready=0. Wait until the last beat leaves lane 4, then go to IDLE.
- exp_bias changes only on the first accept of a burst. in_exp_bias is ignored at all other times.
- Lane timing for a beat accepted at edge t:
  - img1/wgt1/psum carry it during cycle t+1 (registered).
  - Lane k carries it during cycle t+1+(k-1)*SKEW.
- Bubbles: a cycle in RUN with in_valid=0 injects an invalid slot.
  - Invalid slots propagate down each lane exactly like data.
  - Any lane holding an invalid slot drives zeros (img, wgt, and psum for lane 1).
- en=1 in any cycle where at least one lane holds a valid slot; otherwise en=0.
- done=1 in exactly the cycle img4 carries the in_last beat. The next cycle, state is IDLE and busy=0.
- beat_cnt holds its value in IDLE until the next burst's first accept.
- A new burst may be accepted in the cycle after done (IDLE). No overlap with the draining burst occurs.
- The skew line is a per-lane shift register: lane k is (k-1)*SKEW deep, plus the common input register. Total storage per lane is independent of burst length.

Test Plan:
1. Reset values: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0; all outputs, en, done and busy are 0. Release rst -> in_ready=1 next cycle.
2. Single-beat burst, SKEW=1: accept at edge t with img lanes 0x000001..0x000004, psum 0x3C00, in_last=1 -> img1=1 and psum=0x3C00 at t+1; img2=2 at t+2; img3=3 at t+3; img4=4 at t+4; done=1 only at t+4; en=1 for t+1..t+4; beat_cnt=1; in_ready=0 for t+1..t+4.
3. 8-beat back-to-back burst, SKEW=2 -> lane4 beat n appears at t+n+6; en continuous for 14 cycles; done pulses once; beat_cnt=8.
4. Bubble: beats A, idle, B (B last), SKEW=1 -> each lane shows A, zeros, B in consecutive cycles; en stays 1 through the bubble cycle.
5. exp_bias change: burst starts with in_exp_bias=15, then 7 is applied mid-burst -> exp_bias stays 15 until the next burst's first accept.
6. Reset mid-burst: assert rst=0 for one cycle after 3 beats -> all outputs 0 next cycle; no done pulse; a new burst after release behaves as in scenario 2.
